// File: rtl/smi_pkg.sv
// Shared constants and FSM state type for the MDIO (SMI) responder.
// Frame layout: preamble, ST, OP, PHYAD, REGAD, TA, 16-bit data.
package smi_pkg;
    localparam logic [1:0] ST    = 2'b01;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;

    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W  = 16;
    localparam int CNT_W   = 4;
    localparam int PRE_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_WDATA,
        S_RDATA
    } smi_state_e;
endpackage

// File: rtl/smi_sync_edge.sv
// Brings mdc and mdio_in into the clk domain and flags each MDC rising edge.
// Both lines go through the same depth so mdio_s is aligned with mdc_rise.
module smi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic mdc,
    input  logic mdio_in,
    output logic mdc_rise,
    output logic mdio_s
);
    logic mdc_meta_q, mdc_meta_d;
    logic mdc_sync_q, mdc_sync_d;
    logic mdc_prev_q, mdc_prev_d;
    logic dio_meta_q, dio_meta_d;
    logic dio_sync_q, dio_sync_d;

    always_comb begin
        mdc_meta_d = mdc;
        mdc_sync_d = mdc_meta_q;
        mdc_prev_d = mdc_sync_q;
        dio_meta_d = mdio_in;
        dio_sync_d = dio_meta_q;
    end

    // Reset to 1 so an idle-high bus never looks like a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_meta_q <= 1'b1;
            mdc_sync_q <= 1'b1;
            mdc_prev_q <= 1'b1;
            dio_meta_q <= 1'b1;
            dio_sync_q <= 1'b1;
        end else begin
            mdc_meta_q <= mdc_meta_d;
            mdc_sync_q <= mdc_sync_d;
            mdc_prev_q <= mdc_prev_d;
            dio_meta_q <= dio_meta_d;
            dio_sync_q <= dio_sync_d;
        end
    end

    assign mdc_rise = mdc_sync_q & ~mdc_prev_q;
    assign mdio_s   = dio_sync_q;
endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: decodes frames sampled on MDC rises and turns
// them into one-clk register read/write strobes; drives read data back.
module mdio_responder
    import smi_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR     = 5'd1,
    parameter int         PREAMBLE_MIN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic [4:0]  reg_addr,
    output logic        reg_wr_en,
    output logic [15:0] reg_wr_data,
    output logic        reg_rd_en,
    input  logic [15:0] reg_rd_data,
    output logic        frame_err
);
    localparam logic [PRE_W-1:0] PRE_MIN_V = PRE_W'(PREAMBLE_MIN);

    logic mdc_rise, mdio_s;

    smi_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .mdc      (mdc),
        .mdio_in  (mdio_in),
        .mdc_rise (mdc_rise),
        .mdio_s   (mdio_s)
    );

    smi_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic                op_first_q, op_first_d;
    logic                is_rd_q, is_rd_d;
    logic [3:0]          phy_q, phy_d;
    logic                last_q, last_d;
    logic [REGAD_W-1:0]  reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [DATA_W-1:0]   rd_sr_q, rd_sr_d;
    logic                rd_en_q, rd_en_d;
    logic                rd_dly_q, rd_dly_d;
    logic                wr_en_q, wr_en_d;
    logic                err_q, err_d;
    logic                oe_q, oe_d;
    logic                out_q, out_d;
    logic [1:0]          op_bits;
    logic [PHYAD_W-1:0]  phy_bits;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pre_d      = pre_q;
        op_first_d = op_first_q;
        is_rd_d    = is_rd_q;
        phy_d      = phy_q;
        last_d     = last_q;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        rd_sr_d    = rd_sr_q;
        oe_d       = oe_q;
        out_d      = out_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        err_d      = 1'b0;
        rd_dly_d   = rd_en_q;
        op_bits    = {op_first_q, mdio_s};
        phy_bits   = {phy_q, mdio_s};

        // reg_rd_data is valid the clk after the read strobe
        if (rd_dly_q) rd_sr_d = reg_rd_data;

        if (mdc_rise) begin
            case (state_q)
                S_IDLE: begin
                    if (mdio_s) begin
                        if (pre_q < PRE_MIN_V) pre_d = pre_q + 1'b1;
                    end else begin
                        if (pre_q >= PRE_MIN_V) state_d = S_ST;
                        pre_d = '0;
                    end
                end
                S_ST: begin
                    if ({1'b0, mdio_s} == ST) begin
                        state_d = S_OP;
                        cnt_d   = '0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                        pre_d   = '0;
                    end
                end
                S_OP: begin
                    op_first_d = mdio_s;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == 4'd1) begin
                        cnt_d = '0;
                        if (op_bits == OP_WR || op_bits == OP_RD) begin
                            is_rd_d = (op_bits == OP_RD);
                            state_d = S_PHYAD;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                            pre_d   = '0;
                        end
                    end
                end
                S_PHYAD: begin
                    phy_d = phy_bits[3:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == 4'd4) begin
                        cnt_d = '0;
                        if (phy_bits == PHY_ADDR) begin
                            state_d = S_REGAD;
                        end else begin
                            state_d = S_IDLE;
                            pre_d   = '0;
                        end
                    end
                end
                S_REGAD: begin
                    reg_addr_d = {reg_addr_q[3:0], mdio_s};
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == 4'd4) begin
                        cnt_d   = '0;
                        rd_en_d = is_rd_q;
                        state_d = S_TA;
                    end
                end
                S_TA: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == 4'd1) begin
                        cnt_d = '0;
                        if (is_rd_q) begin
                            oe_d    = 1'b1;
                            out_d   = 1'b0;
                            last_d  = 1'b0;
                            state_d = S_RDATA;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end
                end
                S_WDATA: begin
                    wr_data_d = {wr_data_q[14:0], mdio_s};
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == 4'd15) begin
                        wr_en_d = 1'b1;
                        state_d = S_IDLE;
                        pre_d   = '0;
                    end
                end
                S_RDATA: begin
                    // The 4-bit counter wraps after D0, so last_q marks the release rise.
                    if (last_q) begin
                        oe_d    = 1'b0;
                        out_d   = 1'b1;
                        last_d  = 1'b0;
                        cnt_d   = '0;
                        pre_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        out_d   = rd_sr_q[15];
                        rd_sr_d = {rd_sr_q[14:0], 1'b0};
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == 4'd15) last_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pre_q      <= '0;
            op_first_q <= 1'b0;
            is_rd_q    <= 1'b0;
            phy_q      <= '0;
            last_q     <= 1'b0;
            reg_addr_q <= '0;
            wr_data_q  <= '0;
            rd_sr_q    <= '0;
            rd_en_q    <= 1'b0;
            rd_dly_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            err_q      <= 1'b0;
            oe_q       <= 1'b0;
            out_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            op_first_q <= op_first_d;
            is_rd_q    <= is_rd_d;
            phy_q      <= phy_d;
            last_q     <= last_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            rd_sr_q    <= rd_sr_d;
            rd_en_q    <= rd_en_d;
            rd_dly_q   <= rd_dly_d;
            wr_en_q    <= wr_en_d;
            err_q      <= err_d;
            oe_q       <= oe_d;
            out_q      <= out_d;
        end
    end

    assign mdio_out    = out_q;
    assign mdio_oe     = oe_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_data = wr_data_q;
    assign reg_rd_en   = rd_en_q;
    assign frame_err   = err_q;
endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: an MDIO master model with a pulled-up
// shared line, a registered read-data responder and pulse counters.
module tb_mdio_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mdc = 1'b1;
    logic        m_oe = 1'b0;
    logic        m_drv = 1'b1;
    logic        mdio_in;
    logic        mdio_out, mdio_oe;
    logic [4:0]  reg_addr;
    logic        reg_wr_en, reg_rd_en, frame_err;
    logic [15:0] reg_wr_data;
    logic [15:0] reg_rd_data = 16'hdead;
    logic [15:0] rd_mem [32];

    int n_cmp = 0;
    int n_fail = 0;
    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, oe_cnt = 0;
    logic [4:0]  wr_addr_cap = 5'h1f;
    logic [15:0] wr_data_cap = 16'h0;

    always #5 clk = ~clk;

    // Pad: responder wins when enabled, otherwise master or the pull-up.
    assign mdio_in = mdio_oe ? mdio_out : (m_oe ? m_drv : 1'b1);

    mdio_responder #(.PHY_ADDR(5'd1), .PREAMBLE_MIN(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mdc         (mdc),
        .mdio_in     (mdio_in),
        .mdio_out    (mdio_out),
        .mdio_oe     (mdio_oe),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .frame_err   (frame_err)
    );

    // Register file answers one clk after the strobe, garbage otherwise.
    always @(posedge clk) reg_rd_data <= reg_rd_en ? rd_mem[reg_addr] : 16'hdead;

    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_wr_en) begin
                wr_cnt++;
                wr_addr_cap = reg_addr;
                wr_data_cap = reg_wr_data;
            end
            if (reg_rd_en) rd_cnt++;
            if (frame_err) err_cnt++;
            if (mdio_oe) oe_cnt++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        mdc = 1'b0; m_oe = 1'b1; m_drv = b;
        wait_clk(6);
        mdc = 1'b1;
        wait_clk(6);
    endtask

    // Master released; sample the line mid-low (reflects the previous rise).
    task automatic rel_bit(output logic oe_s, output logic out_s);
        mdc = 1'b0; m_oe = 1'b0;
        wait_clk(4);
        oe_s = mdio_oe; out_s = mdio_out;
        wait_clk(2);
        mdc = 1'b1;
        wait_clk(6);
    endtask

    task automatic send_field(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_write(input logic [4:0] phy, input logic [4:0] ra,
                            input logic [15:0] data, input logic [1:0] ta);
        send_bit(1'b1);
        send_field(16'h0001, 2);
        send_field(16'h0001, 2);
        send_field({11'd0, phy}, 5);
        send_field({11'd0, ra}, 5);
        send_field({14'd0, ta}, 2);
        send_field(data, 16);
    endtask

    task automatic read_hdr(input logic [4:0] phy, input logic [4:0] ra);
        send_bit(1'b1);
        send_field(16'h0001, 2);
        send_field(16'h0002, 2);
        send_field({11'd0, phy}, 5);
        send_field({11'd0, ra}, 5);
    endtask

    task automatic do_read(input logic [4:0] phy, input logic [4:0] ra,
                           output logic [15:0] word, output logic ta1_oe,
                           output logic ta2_oe, output logic ta2_out,
                           output logic data_oe_all, output logic end_oe,
                           output logic end_out);
        logic o, d;
        read_hdr(phy, ra);
        rel_bit(o, d);
        rel_bit(ta1_oe, d);
        rel_bit(ta2_oe, ta2_out);
        data_oe_all = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            rel_bit(o, d);
            word[i] = d;
            if (!o) data_oe_all = 1'b0;
        end
        mdc = 1'b0; m_oe = 1'b0;
        wait_clk(4);
        end_oe = mdio_oe; end_out = mdio_out;
        wait_clk(2);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (mdio_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe: got %b want 0", mdio_oe); end
        n_cmp++; if (mdio_out !== 1'b1) begin n_fail++; $display("FAIL rst_out: got %b want 1", mdio_out); end
        n_cmp++; if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b want 0", reg_wr_en); end
        n_cmp++; if (reg_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b want 0", reg_rd_en); end
        n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", frame_err); end
        n_cmp++; if (reg_addr !== 5'd0) begin n_fail++; $display("FAIL rst_addr: got %h want 00", reg_addr); end
        n_cmp++; if (reg_wr_data !== 16'd0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0000", reg_wr_data); end
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_write();
        int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt, o0 = oe_cnt;
        do_write(5'd1, 5'h00, 16'h1140, 2'b00);
        n_cmp++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL wr_pulses: got %0d want 1", wr_cnt - w0); end
        n_cmp++; if (wr_addr_cap !== 5'h00) begin n_fail++; $display("FAIL wr_addr: got %h want 00", wr_addr_cap); end
        n_cmp++; if (wr_data_cap !== 16'h1140) begin n_fail++; $display("FAIL wr_data: got %h want 1140", wr_data_cap); end
        n_cmp++; if (oe_cnt - o0 !== 0) begin n_fail++; $display("FAIL wr_oe: got %0d oe clks want 0", oe_cnt - o0); end
        n_cmp++; if ((rd_cnt - r0) + (err_cnt - e0) !== 0) begin n_fail++; $display("FAIL wr_other: got %0d rd/err pulses want 0", (rd_cnt - r0) + (err_cnt - e0)); end
    endtask

    task automatic test_read();
        logic [15:0] word;
        logic ta1, ta2o, ta2d, all_oe, eo, ed;
        int r0 = rd_cnt, e0 = err_cnt;
        rd_mem[2] = 16'h0022;
        do_read(5'd1, 5'h02, word, ta1, ta2o, ta2d, all_oe, eo, ed);
        n_cmp++; if (rd_cnt - r0 !== 1) begin n_fail++; $display("FAIL rd_pulses: got %0d want 1", rd_cnt - r0); end
        n_cmp++; if (ta1 !== 1'b0) begin n_fail++; $display("FAIL rd_ta1_oe: got %b want 0", ta1); end
        n_cmp++; if ({ta2o, ta2d} !== 2'b10) begin n_fail++; $display("FAIL rd_ta2: got oe/out %b want 10", {ta2o, ta2d}); end
        n_cmp++; if (word !== 16'h0022) begin n_fail++; $display("FAIL rd_data: got %h want 0022", word); end
        n_cmp++; if (all_oe !== 1'b1) begin n_fail++; $display("FAIL rd_data_oe: got %b want 1", all_oe); end
        n_cmp++; if ({eo, ed} !== 2'b01) begin n_fail++; $display("FAIL rd_release: got oe/out %b want 01", {eo, ed}); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL rd_err: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_phy_mismatch();
        logic [15:0] word;
        logic ta1, ta2o, ta2d, all_oe, eo, ed;
        int r0 = rd_cnt, e0 = err_cnt, o0 = oe_cnt;
        do_read(5'd3, 5'h00, word, ta1, ta2o, ta2d, all_oe, eo, ed);
        n_cmp++; if (rd_cnt - r0 !== 0) begin n_fail++; $display("FAIL phy_rd: got %0d want 0", rd_cnt - r0); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL phy_err: got %0d want 0", err_cnt - e0); end
        n_cmp++; if (oe_cnt - o0 !== 0) begin n_fail++; $display("FAIL phy_oe: got %0d oe clks want 0", oe_cnt - o0); end
    endtask

    task automatic test_frame_errors();
        int e0 = err_cnt, w0 = wr_cnt, r0 = rd_cnt;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        n_cmp++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL err_st00: got %0d want 1", err_cnt - e0); end
        e0 = err_cnt;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        n_cmp++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL err_op11: got %0d want 1", err_cnt - e0); end
        n_cmp++; if ((wr_cnt - w0) + (rd_cnt - r0) !== 0) begin n_fail++; $display("FAIL err_regs: got %0d pulses want 0", (wr_cnt - w0) + (rd_cnt - r0)); end
        do_write(5'd1, 5'h1f, 16'hbeef, 2'b10);
        n_cmp++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL err_recover_wr: got %0d want 1", wr_cnt - w0); end
        n_cmp++; if ({wr_addr_cap, wr_data_cap} !== {5'h1f, 16'hbeef}) begin n_fail++; $display("FAIL err_recover_val: got %h/%h want 1f/beef", wr_addr_cap, wr_data_cap); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] word;
        logic ta1, ta2o, ta2d, all_oe, eo, ed;
        int w0 = wr_cnt, r0 = rd_cnt;
        rd_mem[11] = 16'hc0de;
        do_write(5'd1, 5'h0a, 16'h5a3c, 2'b10);
        do_read(5'd1, 5'h0b, word, ta1, ta2o, ta2d, all_oe, eo, ed);
        n_cmp++; if ({wr_addr_cap, wr_data_cap} !== {5'h0a, 16'h5a3c}) begin n_fail++; $display("FAIL b2b_wr: got %h/%h want 0a/5a3c", wr_addr_cap, wr_data_cap); end
        n_cmp++; if ((wr_cnt - w0) * 10 + (rd_cnt - r0) !== 11) begin n_fail++; $display("FAIL b2b_pulses: got wr %0d rd %0d want 1 1", wr_cnt - w0, rd_cnt - r0); end
        n_cmp++; if (word !== 16'hc0de) begin n_fail++; $display("FAIL b2b_rd_data: got %h want c0de", word); end
    endtask

    task automatic test_reset_mid_read();
        logic [15:0] word;
        logic o, d, ta1, ta2o, ta2d, all_oe, eo, ed;
        int r0 = rd_cnt, e0 = err_cnt, w0 = wr_cnt;
        rd_mem[3] = 16'ha5c3;
        read_hdr(5'd1, 5'h03);
        for (int i = 0; i < 10; i++) rel_bit(o, d);
        n_cmp++; if (mdio_oe !== 1'b1) begin n_fail++; $display("FAIL mid_driving: got %b want 1", mdio_oe); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({mdio_oe, mdio_out} !== 2'b01) begin n_fail++; $display("FAIL mid_rst_line: got oe/out %b want 01", {mdio_oe, mdio_out}); end
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        n_cmp++; if ((err_cnt - e0) + (wr_cnt - w0) !== 0) begin n_fail++; $display("FAIL mid_pulses: got %0d want 0", (err_cnt - e0) + (wr_cnt - w0)); end
        r0 = rd_cnt;
        rd_mem[1] = 16'h796d;
        do_read(5'd1, 5'h01, word, ta1, ta2o, ta2d, all_oe, eo, ed);
        n_cmp++; if (word !== 16'h796d) begin n_fail++; $display("FAIL mid_next_data: got %h want 796d", word); end
        n_cmp++; if (rd_cnt - r0 !== 1) begin n_fail++; $display("FAIL mid_next_rd: got %0d want 1", rd_cnt - r0); end
        n_cmp++; if ({eo, ed} !== 2'b01) begin n_fail++; $display("FAIL mid_next_release: got oe/out %b want 01", {eo, ed}); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rd_mem[i] = 16'hffff;
        test_reset();
        test_write();
        test_read();
        test_phy_mismatch();
        test_frame_errors();
        test_back_to_back();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mdio_responder.md
MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd1: the only PHY address this block answers.
REQ-002 SHALL have parameter PREAMBLE_MIN, default 1: minimum count of consecutive sampled 1s before a start 0 is accepted.
REQ-003 SHALL have port clk  input  1: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous assert and active-low.
REQ-005 SHALL have port mdc  input  1: management clock from the MDIO master, asynchronous to clk, period at least 8 clk.
REQ-006 SHALL have port mdio_in  input  1: management data line as sampled from the pad.
REQ-007 SHALL have port mdio_out  output  1: data this block drives onto the line.
REQ-008 SHALL have port mdio_oe  output  1: output enable; 1 means mdio_out drives the pad.
REQ-009 SHALL have port reg_addr  output  5: register address of the current frame.
REQ-010 SHALL have port reg_wr_en  output  1: one-clk pulse that commits reg_wr_data to reg_addr.
REQ-011 SHALL have port reg_wr_data  output  16: write data from the frame.
REQ-012 SHALL have port reg_rd_en  output  1: one-clk read request for reg_addr.
REQ-013 SHALL have port reg_rd_data  input  16: read data, valid on the clk after reg_rd_en.
REQ-014 SHALL have port frame_err  output  1: one-clk pulse on a malformed frame.

Function
REQ-015 SHALL pass mdc and mdio_in through 2-flop synchronizers; the MDC rise is defined as synced mdc=1 while the previous synced value was 0.
REQ-016 SHALL sample synced mdio_in only on MDC rise; one rise is one frame bit.
REQ-017 SHALL run FSM states IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, using a 4-bit bit counter per field.
REQ-018 IDLE SHALL count consecutive 1s, saturating at PREAMBLE_MIN; a 0 with count>=PREAMBLE_MIN moves to ST; a 0 with count<PREAMBLE_MIN clears the count.
REQ-019 ST SHALL require bit 1: if 1, go to OP; if 0, pulse frame_err and return to IDLE with the count cleared.
REQ-020 OP bits 01 SHALL mean write and 10 SHALL mean read; 00 or 11 SHALL pulse frame_err and return to IDLE.
REQ-021 PHYAD SHALL shift in 5 bits, MSB first; on mismatch with PHY_ADDR, return silently to IDLE, with no drive and no pulses.
REQ-022 REGAD SHALL shift in 5 bits, MSB first, into reg_addr; on a matched read, pulse reg_rd_en on the clk after the 5th bit's rise.
REQ-023 TA on a write SHALL ignore the 2 line values, since the master may drive 00.
REQ-024 TA on a read SHALL set mdio_oe=0 at the 1st TA rise, and mdio_oe=1 with mdio_out=0 at the 2nd TA rise.
REQ-025 SHALL load reg_rd_data into a 16-bit shift register on the clk after reg_rd_en.
REQ-026 RDATA SHALL drive D15..D0, one bit per MDC rise, at rises 17..32 counted from the ST 0 bit as rise 1.
REQ-027 SHALL update mdio_out within 4 clk of each rise, so the master's mid-low sample sees a stable bit.
REQ-028 SHALL set mdio_oe=0 and mdio_out=1 at the rise after D0, then go to IDLE.
REQ-029 WDATA SHALL shift 16 bits, MSB first, into reg_wr_data, then pulse reg_wr_en once on the clk after the 16th rise, then go to IDLE.
REQ-030 The IDLE entered after a completed frame SHALL need a fresh preamble; one trailing 1 bit satisfies the default.
REQ-031 mdio_oe SHALL never be 1 outside TA2/RDATA of an address-matched read.
REQ-032 A stalled mdc SHALL freeze the FSM; there is no timeout.

Reset
REQ-033 rst_n low SHALL immediately force: IDLE, counts 0, mdio_oe=0, mdio_out=1, reg_wr_en=0, reg_rd_en=0, frame_err=0, reg_addr=0, reg_wr_data=0, synchronizers=1.
REQ-034 Reset mid-frame SHALL abort the frame with no pulse; the next frame after release SHALL decode normally.

Structure
REQ-035 Package smi_pkg SHALL hold ST=2'b01, OP_WR=2'b01, OP_RD=2'b10, field widths, and the FSM state enum.
REQ-036 Sub-module smi_sync_edge SHALL hold the mdc/mdio_in synchronizers and rise detection; all other logic is one FSM in mdio_responder.

Verification
REQ-037 Write frame, PHY 1, reg 5'h00, data 16'h1140, TA=00, 1-bit preamble -> one reg_wr_en, reg_addr=0, reg_wr_data=16'h1140, mdio_oe never 1.
REQ-038 Read frame, PHY 1, reg 5'h02, reg_rd_data=16'h0022 -> reg_rd_en once; line reads Z,0 in TA, then 0000_0000_0010_0010; mdio_oe drops after D0.
REQ-039 Read frame with PHY address 5'd3 -> no reg_rd_en, no frame_err, mdio_oe stays 0.
REQ-040 ST=00, then separately OP=11 -> one frame_err each, no register pulses, and the next valid write decodes.
REQ-041 Back-to-back write then read with one idle 1 between -> both complete, data correct.
REQ-042 rst_n low at RDATA bit 8 -> mdio_oe=0 that clk; after release, a read of reg 5'h01 returns correct data.
